// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// freeze, flush and an optional 2-entry skid buffer; counts output transfers.
module pipe_stage_reg #(
   parameter int DATA_W     = 32,
   parameter int SKID       = 1,
   parameter int FLUSH_ZERO = 1,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              freeze,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  xfer_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKIDF = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] main_nxt;
   logic [DATA_W-1:0] skid_q;
   logic [DATA_W-1:0] skid_nxt;
   logic [CNT_W-1:0]  cnt_q;
   logic              in_fire;
   logic              out_fire;

   // The skid variant only looks at its own state, so ready does not depend on out_ready.
   generate
      if (SKID != 0) begin : g_skid_ready
         assign in_ready = rst_b & ~freeze & (state != SKIDF);
      end else begin : g_reg_ready
         assign in_ready = rst_b & ~freeze & ((state == EMPTY) | out_ready);
      end
   endgenerate

   assign out_valid = (state != EMPTY);
   assign out_data  = main_q;
   assign xfer_cnt  = cnt_q;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready & ~freeze;

   always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      if (flush) begin
         state_nxt = EMPTY;
         if (FLUSH_ZERO != 0) begin
            main_nxt = '0;
            skid_nxt = '0;
         end
      end else begin
         unique case (state)
            EMPTY: begin
               if (in_fire) begin
                  state_nxt = FULL;
                  main_nxt  = in_data;
               end
            end
            FULL: begin
               if (in_fire && out_fire) begin
                  main_nxt = in_data;
               end else if (in_fire) begin
                  state_nxt = SKIDF;
                  skid_nxt  = in_data;
               end else if (out_fire) begin
                  state_nxt = EMPTY;
               end
            end
            SKIDF: begin
               if (out_fire) begin
                  state_nxt = FULL;
                  main_nxt  = skid_q;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
         cnt_q  <= '0;
      end else begin
         state  <= state_nxt;
         main_q <= main_nxt;
         skid_q <= skid_nxt;
         if (out_fire) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: a skid-buffer instance and a single-register instance
// share stimulus; each is compared against a queue-based model.
module tb_pipe_stage_reg;

   logic       clk = 1'b0;
   logic       rst_b;
   logic       freeze;
   logic       flush;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_ready;

   logic       s_in_ready, s_out_valid;
   logic [7:0] s_out_data;
   logic [3:0] s_xfer_cnt;
   logic       r_in_ready, r_out_valid;
   logic [7:0] r_out_data;
   logic [15:0] r_xfer_cnt;

   int checkCount = 0;
   int failCount  = 0;

   logic [7:0] qS[$];
   logic [7:0] qR[$];
   logic [7:0] heldS, heldR;
   int         cntS, cntR;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(8), .SKID(1), .FLUSH_ZERO(1), .CNT_W(4)) u_skid (
      .clk(clk), .rst_b(rst_b), .freeze(freeze), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
      .xfer_cnt(s_xfer_cnt)
   );

   pipe_stage_reg #(.DATA_W(8), .SKID(0), .FLUSH_ZERO(1), .CNT_W(16)) u_reg (
      .clk(clk), .rst_b(rst_b), .freeze(freeze), .flush(flush),
      .in_valid(in_valid), .in_ready(r_in_ready), .in_data(in_data),
      .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data),
      .xfer_cnt(r_xfer_cnt)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs, compare outputs to the models, then advance the models at the edge.
   task automatic applyStimulus(input logic r, input logic fz, input logic fl,
                                input logic iv, input logic [7:0] d, input logic ordy);
      logic       rdyS, rdyR, ofS, ofR;
      logic [7:0] tmp;
      @(negedge clk);
      rst_b = r; freeze = fz; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
      #1;
      rdyS = r & ~fz & (qS.size() < 2);
      rdyR = r & ~fz & ((qR.size() == 0) | ordy);
      checkOutput("skid_in_ready", 32'(s_in_ready), 32'(rdyS));
      checkOutput("skid_out_valid", 32'(s_out_valid), 32'(qS.size() > 0));
      checkOutput("skid_out_data", 32'(s_out_data), 32'((qS.size() > 0) ? qS[0] : heldS));
      checkOutput("skid_xfer_cnt", 32'(s_xfer_cnt), 32'(cntS));
      checkOutput("reg_in_ready", 32'(r_in_ready), 32'(rdyR));
      checkOutput("reg_out_valid", 32'(r_out_valid), 32'(qR.size() > 0));
      checkOutput("reg_out_data", 32'(r_out_data), 32'((qR.size() > 0) ? qR[0] : heldR));
      checkOutput("reg_xfer_cnt", 32'(r_xfer_cnt), 32'(cntR));
      @(posedge clk);
      if (!r) begin
         qS.delete(); qR.delete();
         heldS = 8'h00; heldR = 8'h00;
         cntS = 0; cntR = 0;
      end else begin
         ofS = (qS.size() > 0) && ordy && !fz;
         ofR = (qR.size() > 0) && ordy && !fz;
         if (ofS) cntS = (cntS + 1) % 16;
         if (ofR) cntR = (cntR + 1) % 65536;
         if (fl) begin
            qS.delete(); qR.delete();
            heldS = 8'h00; heldR = 8'h00;
         end else begin
            if (ofS) tmp = qS.pop_front();
            if (iv && rdyS) qS.push_back(d);
            if (qS.size() > 0) heldS = qS[0];
            if (ofR) tmp = qR.pop_front();
            if (iv && rdyR) qR.push_back(d);
            if (qR.size() > 0) heldR = qR[0];
         end
      end
   endtask

   initial begin
      rst_b = 1'b0; freeze = 1'b1; flush = 1'b1;
      in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      heldS = 8'h00; heldR = 8'h00; cntS = 0; cntR = 0;

      // Reset dominates freeze and flush.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);
      #1;
      checkOutput("reset_in_ready", 32'(s_in_ready), 32'd0);
      checkOutput("reset_out_valid", 32'(s_out_valid), 32'd0);
      checkOutput("reset_out_data", 32'(s_out_data), 32'd0);

      // Back-to-back stream.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      #1;
      checkOutput("stream_cnt_skid", 32'(s_xfer_cnt), 32'd3);
      checkOutput("stream_cnt_reg", 32'(r_xfer_cnt), 32'd3);

      // Fill the skid buffer under backpressure, then drain.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h0B, 1'b0);
      #1;
      checkOutput("skidf_in_ready", 32'(s_in_ready), 32'd0);
      checkOutput("skidf_head", 32'(s_out_data), 32'h0A);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

      // Freeze while full with input pending.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

      // Flush while the skid buffer holds two entries.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h66, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h0C, 1'b0);
      #1;
      checkOutput("flush_out_valid", 32'(s_out_valid), 32'd0);
      checkOutput("flush_out_data", 32'(s_out_data), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

      // Counter wrap on the 4-bit instance.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'(i + 1), 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      #1;
      checkOutput("wrap_cnt", 32'(s_xfer_cnt), 32'd1);

      // Random traffic including occasional reset, freeze and flush.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 49) != 0),
                       ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 15) == 0),
                       ($urandom_range(0, 9) < 7),
                       8'($urandom),
                       ($urandom_range(0, 9) < 6));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
